// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c_controller between N_CLIENTS requesters
module i2c_arbiter #(
  parameter int N_CLIENTS      = 4,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int GW             = $clog2(N_CLIENTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CLIENTS-1:0]    c_valid,
  output logic [N_CLIENTS-1:0]    c_ready,
  input  logic [N_CLIENTS-1:0]    c_mode,
  input  logic [7*N_CLIENTS-1:0]  c_addr,
  input  logic [12*N_CLIENTS-1:0] c_data,
  output logic [N_CLIENTS-1:0]    c_done,
  output logic                    c_err,
  output logic [11:0]             c_rdata,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_mode,
  output logic [6:0]              m_addr,
  output logic [11:0]             m_data,
  input  logic                    m_o_valid,
  input  logic [11:0]             m_o_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [GW-1:0]          winner;
  logic [GW-1:0]          cand;
  logic                   found;
  logic                   sel_mode;
  logic [6:0]             sel_addr;
  logic [11:0]            sel_data;
  logic                   timeout;
  logic [N_CLIENTS-1:0]   grant_onehot;

  // Search starts just past the last grant so the previous winner ranks last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      cand = GW'((int'(grant_id) + k) % N_CLIENTS);
      if (!found && c_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_mode = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (winner == GW'(i)) begin
        sel_mode = c_mode[i];
        sel_addr = c_addr[7*i +: 7];
        sel_data = c_data[12*i +: 12];
      end
    end
  end

  always_comb begin
    c_ready = '0;
    if (state == IDLE && found) c_ready[winner] = 1'b1;
  end

  assign timeout      = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign grant_onehot = N_CLIENTS'(1) << grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
      m_mode   <= 1'b0;
      m_addr   <= '0;
      m_data   <= '0;
      c_done   <= '0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
      grant_id <= GW'(N_CLIENTS - 1);
    end else if ((state == ISSUE || state == WAIT_BUSY || state == WAIT_DONE) && timeout) begin
      m_valid <= 1'b0;
      c_err   <= 1'b1;
      c_done  <= grant_onehot;
      state   <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            m_mode   <= sel_mode;
            m_addr   <= sel_addr;
            m_data   <= sel_data;
            grant_id <= winner;
            busy     <= 1'b1;
            cnt      <= '0;
            m_valid  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          cnt <= cnt + 1'b1;
          if (!m_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (m_ready) begin
            c_done <= grant_onehot;
            state  <= DONE;
          end
        end
        DONE: begin
          // A timed-out read never captures the controller's stale output.
          if (m_mode && m_o_valid && !c_err) c_rdata <= m_o_data;
          c_done <= '0;
          c_err  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - scoreboard bench for i2c_arbiter with a simple i2c_controller model
module tb_i2c_arbiter;

  localparam int N  = 4;
  localparam int TO = 400;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      c_valid;
  logic [N-1:0]      c_ready;
  logic [N-1:0]      c_mode;
  logic [7*N-1:0]    c_addr;
  logic [12*N-1:0]   c_data;
  logic [N-1:0]      c_done;
  logic              c_err;
  logic [11:0]       c_rdata;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              m_valid;
  logic              m_ready;
  logic              m_mode;
  logic [6:0]        m_addr;
  logic [11:0]       m_data;
  logic              m_o_valid;
  logic [11:0]       m_o_data;

  logic              hang = 1'b0;
  logic              model_rvalid = 1'b0;
  logic [11:0]       model_rdata = 12'h000;
  int                acc_dly = 3;
  int                busy_len = 4;

  logic              cl_mode [N];
  logic [6:0]        cl_addr [N];
  logic [11:0]       cl_data [N];
  int                issued  [N] = '{default: 0};
  int                taken   [N] = '{default: 0};

  typedef struct {
    int          id;
    logic        err;
    logic        mode;
    logic [6:0]  addr;
    logic [11:0] data;
    logic [11:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [11:0] exp_rd = 12'h000;

  assign m_o_valid = model_rvalid;
  assign m_o_data  = model_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_arbiter #(.N_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_mode(c_mode), .c_addr(c_addr), .c_data(c_data),
    .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata), .busy(busy), .grant_id(grant_id),
    .m_valid(m_valid), .m_ready(m_ready), .m_mode(m_mode), .m_addr(m_addr), .m_data(m_data),
    .m_o_valid(m_o_valid), .m_o_data(m_o_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic post(input int id, input logic mode, input logic [6:0] addr, input logic [11:0] data, input int count);
    cl_mode[id] = mode;
    cl_addr[id] = addr;
    cl_data[id] = data;
    issued[id]  = issued[id] + count;
  endtask

  task automatic push(input int id, input logic err, input logic mode, input logic [6:0] addr, input logic [11:0] data);
    exp_t e;
    if (mode && !err && model_rvalid) exp_rd = model_rdata;
    e.id = id; e.err = err; e.mode = mode; e.addr = addr; e.data = data; e.rdata = exp_rd;
    q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic check_reset_values();
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_c_done",   32'(c_done),   32'd0);
    check("rst_c_err",    32'(c_err),    32'd0);
    check("rst_c_rdata",  32'(c_rdata),  32'd0);
    check("rst_grant_id", 32'(grant_id), 32'(N - 1));
    check("rst_m_mode",   32'(m_mode),   32'd0);
    check("rst_m_addr",   32'(m_addr),   32'd0);
    check("rst_m_data",   32'(m_data),   32'd0);
  endtask

  // Client drivers: hold each request until its transfer, then scramble the slice.
  initial begin
    logic [N-1:0] hs;
    c_valid = '0;
    c_mode  = '1;
    c_addr  = '1;
    c_data  = '1;
    forever begin
      @(negedge clk);
      hs = c_valid & c_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) taken[i]++;
        c_valid[i]         = (issued[i] != taken[i]);
        c_mode[i]          = c_valid[i] ? cl_mode[i] : 1'b1;
        c_addr[7*i +: 7]   = c_valid[i] ? cl_addr[i] : 7'h7F;
        c_data[12*i +: 12] = c_valid[i] ? cl_data[i] : 12'hFFF;
      end
    end
  end

  // Controller model: accept after acc_dly cycles, stay busy busy_len cycles, then ready.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (m_valid && !hang) begin
        repeat (acc_dly) begin
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
      end
    end
  end

  // Monitor: pops one expectation per c_done cycle; checks c_rdata the cycle after.
  initial begin
    exp_t        e;
    logic        busy_q = 1'b0;
    int          busy_start = 0;
    logic        pending_rd = 1'b0;
    logic [11:0] rd_next = 12'h000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_q     = 1'b0;
        pending_rd = 1'b0;
      end else begin
        if (busy && !busy_q) busy_start = cyc;
        busy_q = busy;
        if (|c_ready)
          check("c_ready_onehot", 32'(($countones(c_ready) == 1) && ((c_ready & ~c_valid) == '0)), 32'd1);
        if (pending_rd) begin
          check("c_rdata", 32'(c_rdata), 32'(rd_next));
          pending_rd = 1'b0;
        end
        if (|c_done) begin
          if (q.size() == 0) begin
            check("c_done_unexpected", 32'(c_done), 32'd0);
          end else begin
            e = q.pop_front();
            check("c_done",   32'(c_done),   32'(1 << e.id));
            check("c_err",    32'(c_err),    32'(e.err));
            check("grant_id", 32'(grant_id), 32'(e.id));
            check("busy_done", 32'(busy),    32'd1);
            check("m_mode",   32'(m_mode),   32'(e.mode));
            check("m_addr",   32'(m_addr),   32'(e.addr));
            check("m_data",   32'(m_data),   32'(e.data));
            if (e.err) begin
              check("timeout_latency", 32'(cyc - busy_start), 32'(TO));
              check("timeout_m_valid", 32'(m_valid), 32'd0);
            end
            pending_rd = 1'b1;
            rd_next    = e.rdata;
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    check("rst_c_ready", 32'(c_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single write from client 0.
    post(0, 1'b0, 7'h60, 12'hABC, 1);
    push(0, 1'b0, 1'b0, 7'h60, 12'hABC);
    drain(200);

    // Clients 1 and 3 together with grant_id=0: 1 first, then 3.
    post(1, 1'b0, 7'h11, 12'h101, 1);
    post(3, 1'b0, 7'h33, 12'h303, 1);
    @(negedge clk);
    check("c_ready_rr", 32'(c_ready), 32'b0010);
    push(1, 1'b0, 1'b0, 7'h11, 12'h101);
    push(3, 1'b0, 1'b0, 7'h33, 12'h303);
    drain(200);

    // All four clients hold c_valid for two transactions each.
    for (int i = 0; i < N; i++) post(i, 1'b0, 7'(7'h20 + i), 12'(12'h111 * (i + 1)), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 1'b0, 1'b0, 7'(7'h20 + i), 12'(12'h111 * (i + 1)));
    drain(800);

    // Read by client 2, then a write by client 0 keeps c_rdata.
    model_rvalid = 1'b1;
    model_rdata  = 12'h5A5;
    post(2, 1'b1, 7'h48, 12'h000, 1);
    push(2, 1'b0, 1'b1, 7'h48, 12'h000);
    drain(200);
    post(0, 1'b0, 7'h22, 12'h0F0, 1);
    push(0, 1'b0, 1'b0, 7'h22, 12'h0F0);
    drain(200);

    // Controller hangs on client 1's read; timeout, then client 3 proceeds.
    hang        = 1'b1;
    model_rdata = 12'h3C3;
    post(1, 1'b1, 7'h30, 12'h001, 1);
    post(3, 1'b0, 7'h31, 12'h002, 1);
    push(1, 1'b1, 1'b1, 7'h30, 12'h001);
    push(3, 1'b0, 1'b0, 7'h31, 12'h002);
    n = 0;
    while (!c_done[1] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_seen", 32'(c_done[1]), 32'd1);
    hang = 1'b0;
    drain(200);

    // Reset while the controller is busy (arbiter in WAIT_DONE).
    busy_len = 12;
    post(2, 1'b0, 7'h55, 12'h555, 1);
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 32'(n < 100), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values();
    exp_rd = 12'h000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);

    // First request after reset: client 0 beats client 2.
    post(2, 1'b1, 7'h12, 12'h000, 1);
    post(0, 1'b0, 7'h60, 12'h321, 1);
    @(negedge clk);
    check("c_ready_after_rst", 32'(c_ready), 32'b0001);
    push(0, 1'b0, 1'b0, 7'h60, 12'h321);
    push(2, 1'b0, 1'b1, 7'h12, 12'h000);
    drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
